// File: rtl/wb_arbiter.sv
// wb_arbiter: two Wishbone classic masters share one peripheral tree.
// Arbitration is round-robin, and the grant is held for the whole cyc burst.
// Latency: the grant appears one cycle after cyc is raised while the bus is idle.
//   Once granted, the data and ack paths are combinational.
// Backpressure: the master that is not granted waits with ack=0. A stalled strobe
//   is force-acked after TIMEOUT_CYCLES cycles (0 disables this).
// Ports: io_wbs_*_0 / io_wbs_*_1 are the master-side buses.
//   io_wbs_{adr,datwr,we,sel,stb,cyc,datrd,ack} form the peripheral-side bus.
module wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic        io_wbs_clk,
    input  logic        io_wbs_rst,
    input  logic [31:0] io_wbs_adr_0,
    input  logic [31:0] io_wbs_adr_1,
    input  logic [31:0] io_wbs_datwr_0,
    input  logic [31:0] io_wbs_datwr_1,
    output logic [31:0] io_wbs_datrd_0,
    output logic [31:0] io_wbs_datrd_1,
    input  logic        io_wbs_we_0,
    input  logic        io_wbs_we_1,
    input  logic [3:0]  io_wbs_sel_0,
    input  logic [3:0]  io_wbs_sel_1,
    input  logic        io_wbs_stb_0,
    input  logic        io_wbs_stb_1,
    output logic        io_wbs_ack_0,
    output logic        io_wbs_ack_1,
    input  logic        io_wbs_cyc_0,
    input  logic        io_wbs_cyc_1,
    output logic [31:0] io_wbs_adr,
    output logic [31:0] io_wbs_datwr,
    input  logic [31:0] io_wbs_datrd,
    output logic        io_wbs_we,
    output logic        io_wbs_stb,
    output logic        io_wbs_cyc,
    output logic [3:0]  io_wbs_sel,
    input  logic        io_wbs_ack
);

    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        force_q, force_d;   // current cycle is a forced-ack cycle
    logic        gnt_stb;
    logic        grant_chg;

    // State register
    always_ff @(posedge io_wbs_clk or posedge io_wbs_rst) begin
        if (io_wbs_rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 16'd0;
            force_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            force_q <= force_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (io_wbs_cyc_0 && io_wbs_cyc_1) state_d = last_q ? GNT0 : GNT1;
                else if (io_wbs_cyc_0)            state_d = GNT0;
                else if (io_wbs_cyc_1)            state_d = GNT1;
            end
            GNT0: if (!io_wbs_cyc_0) state_d = io_wbs_cyc_1 ? GNT1 : IDLE;
            GNT1: if (!io_wbs_cyc_1) state_d = io_wbs_cyc_0 ? GNT0 : IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == GNT0 && state_q != GNT0) last_d = 1'b0;
        if (state_d == GNT1 && state_q != GNT1) last_d = 1'b1;

        gnt_stb   = (state_q == GNT0 && io_wbs_stb_0) || (state_q == GNT1 && io_wbs_stb_1);
        grant_chg = (state_d != state_q);

        // A peripheral ack during the forced cycle is ignored. The forced cycle
        // itself never counts as a stall, so the count restarts from zero.
        force_d = TO_EN && !grant_chg && !force_q && gnt_stb && !io_wbs_ack
                  && (cnt_q == TO_LAST);
        if (grant_chg || force_q || force_d || !gnt_stb || io_wbs_ack)
            cnt_d = 16'd0;
        else
            cnt_d = cnt_q + 16'd1;
    end

    // Output logic
    always_comb begin
        io_wbs_adr     = 32'd0;
        io_wbs_datwr   = 32'd0;
        io_wbs_we      = 1'b0;
        io_wbs_sel     = 4'd0;
        io_wbs_stb     = 1'b0;
        io_wbs_cyc     = 1'b0;
        io_wbs_ack_0   = 1'b0;
        io_wbs_ack_1   = 1'b0;
        io_wbs_datrd_0 = 32'd0;
        io_wbs_datrd_1 = 32'd0;
        unique case (state_q)
            GNT0: begin
                io_wbs_adr     = io_wbs_adr_0;
                io_wbs_datwr   = io_wbs_datwr_0;
                io_wbs_we      = io_wbs_we_0;
                io_wbs_sel     = io_wbs_sel_0;
                io_wbs_stb     = io_wbs_stb_0 & ~force_q;
                io_wbs_cyc     = io_wbs_cyc_0;
                io_wbs_ack_0   = force_q | io_wbs_ack;
                io_wbs_datrd_0 = force_q ? TIMEOUT_DATA : io_wbs_datrd;
            end
            GNT1: begin
                io_wbs_adr     = io_wbs_adr_1;
                io_wbs_datwr   = io_wbs_datwr_1;
                io_wbs_we      = io_wbs_we_1;
                io_wbs_sel     = io_wbs_sel_1;
                io_wbs_stb     = io_wbs_stb_1 & ~force_q;
                io_wbs_cyc     = io_wbs_cyc_1;
                io_wbs_ack_1   = force_q | io_wbs_ack;
                io_wbs_datrd_1 = force_q ? TIMEOUT_DATA : io_wbs_datrd;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed bench for wb_arbiter with a scoreboard on master acks.
// Latency: the stimulus issues each request on a fixed cycle schedule.
//   Every expected ack records the cycle in which it must appear.
// Backpressure: a zero-wait peripheral model whose acks can be switched off to stall.
module tb_wb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    logic [31:0] adr0, adr1, dw0, dw1;
    logic        we0, we1, stb0, stb1, cyc0, cyc1;
    logic [3:0]  sel0, sel1;
    logic [31:0] dr0, dr1, p_adr, p_dw, p_dr;
    logic        ack0, ack1, p_we, p_stb, p_cyc, p_ack;
    logic [3:0]  p_sel;
    logic        periph_en;

    // Zero-wait peripheral: read data is the address XOR a fixed pattern.
    assign p_ack = periph_en & p_stb;
    assign p_dr  = p_adr ^ 32'h5A5A_5A5A;

    wb_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
        .io_wbs_clk(clk), .io_wbs_rst(rst),
        .io_wbs_adr_0(adr0), .io_wbs_adr_1(adr1),
        .io_wbs_datwr_0(dw0), .io_wbs_datwr_1(dw1),
        .io_wbs_datrd_0(dr0), .io_wbs_datrd_1(dr1),
        .io_wbs_we_0(we0), .io_wbs_we_1(we1),
        .io_wbs_sel_0(sel0), .io_wbs_sel_1(sel1),
        .io_wbs_stb_0(stb0), .io_wbs_stb_1(stb1),
        .io_wbs_ack_0(ack0), .io_wbs_ack_1(ack1),
        .io_wbs_cyc_0(cyc0), .io_wbs_cyc_1(cyc1),
        .io_wbs_adr(p_adr), .io_wbs_datwr(p_dw), .io_wbs_datrd(p_dr),
        .io_wbs_we(p_we), .io_wbs_stb(p_stb), .io_wbs_cyc(p_cyc),
        .io_wbs_sel(p_sel), .io_wbs_ack(p_ack)
    );

    // Second instance with the timeout disabled and a peripheral that never acks.
    logic        z_cyc, z_stb;
    logic [31:0] z_dr0, z_dr1, z_padr, z_pdw;
    logic        z_ack0, z_ack1, z_pwe, z_pstb, z_pcyc;
    logic [3:0]  z_psel;

    wb_arbiter #(.TIMEOUT_CYCLES(0), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut0 (
        .io_wbs_clk(clk), .io_wbs_rst(rst),
        .io_wbs_adr_0(32'h0000_0100), .io_wbs_adr_1(32'd0),
        .io_wbs_datwr_0(32'd0), .io_wbs_datwr_1(32'd0),
        .io_wbs_datrd_0(z_dr0), .io_wbs_datrd_1(z_dr1),
        .io_wbs_we_0(1'b0), .io_wbs_we_1(1'b0),
        .io_wbs_sel_0(4'hF), .io_wbs_sel_1(4'h0),
        .io_wbs_stb_0(z_stb), .io_wbs_stb_1(1'b0),
        .io_wbs_ack_0(z_ack0), .io_wbs_ack_1(z_ack1),
        .io_wbs_cyc_0(z_cyc), .io_wbs_cyc_1(1'b0),
        .io_wbs_adr(z_padr), .io_wbs_datwr(z_pdw), .io_wbs_datrd(32'h1111_2222),
        .io_wbs_we(z_pwe), .io_wbs_stb(z_pstb), .io_wbs_cyc(z_pcyc),
        .io_wbs_sel(z_psel), .io_wbs_ack(1'b0)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    typedef struct {
        bit          port;
        logic [31:0] datrd;
        logic [31:0] adr;
        bit          stb;
        int          at;
    } exp_t;
    exp_t sbq[$];

    task automatic push(input bit port, input logic [31:0] a, input bit forced, input int at);
        exp_t e;
        e.port  = port;
        e.adr   = a;
        e.datrd = forced ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
        e.stb   = !forced;
        e.at    = at;
        sbq.push_back(e);
    endtask

    // Monitor: every master ack must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (ack0 || ack1)) begin
            chk("sb_single_ack", {63'd0, ack0 & ack1}, 64'd0);
            if (sbq.size() == 0) begin
                chk("sb_unexpected_ack", {62'd0, ack1, ack0}, 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("sb_port", {63'd0, ack1}, {63'd0, e.port});
                chk("sb_datrd", {32'd0, (ack1 ? dr1 : dr0)}, {32'd0, e.datrd});
                chk("sb_other_datrd", {32'd0, (ack1 ? dr0 : dr1)}, 64'd0);
                chk("sb_adr", {32'd0, p_adr}, {32'd0, e.adr});
                chk("sb_stb_cyc", {62'd0, p_stb, p_cyc}, {62'd0, e.stb, 1'b1});
                chk("sb_cycle", 64'(cyc_cnt), 64'(e.at));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input bit c, input logic [31:0] a,
                         input logic [31:0] d, input bit w);
        if (m == 0) begin
            cyc0 = c; stb0 = c; adr0 = a; dw0 = d; we0 = w; sel0 = 4'hF;
        end else begin
            cyc1 = c; stb1 = c; adr1 = a; dw1 = d; we1 = w; sel1 = 4'hF;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    initial begin : stim
        int n;
        int zc;
        set_m(0, 0, 32'd0, 32'd0, 0);
        set_m(1, 0, 32'd0, 32'd0, 0);
        periph_en = 1'b1;
        z_cyc = 1'b0; z_stb = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {23'd0, p_cyc, p_stb, p_we, ack0, ack1, p_sel, p_adr}, 64'd0);
        chk("rst_rdata", {dr0, dr1}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", {23'd0, p_cyc, p_stb, p_we, ack0, ack1, p_sel, p_adr}, 64'd0);

        // Tie right after reset: master 0 first, then master 1 with no bubble.
        step(); n = cyc_cnt;
        set_m(0, 1, 32'h1000_0000, 32'd0, 0);
        set_m(1, 1, 32'h2000_0000, 32'd0, 0);
        push(0, 32'h1000_0000, 0, n + 1);
        step();
        step(); set_m(0, 0, 32'd0, 32'd0, 0);
        push(1, 32'h2000_0000, 0, n + 3);
        step();
        step(); set_m(1, 0, 32'd0, 32'd0, 0);
        step();

        // Fresh reset, then a single write from master 0.
        rst = 1'b1; #2; rst = 1'b0;
        step(); n = cyc_cnt;
        set_m(0, 1, 32'h3000_0004, 32'h1234_5678, 1);
        push(0, 32'h3000_0004, 0, n + 1);
        @(negedge clk);
        chk("grant_latency_cyc", {63'd0, p_cyc}, 64'd0);
        step();
        @(negedge clk);
        chk("wr_adr", {32'd0, p_adr}, 64'h3000_0004);
        chk("wr_datwr", {32'd0, p_dw}, 64'h1234_5678);
        chk("wr_we_sel_cyc_stb", {57'd0, p_we, p_sel, p_cyc, p_stb}, 64'h7F);
        chk("wr_ack1_quiet", {63'd0, ack1}, 64'd0);
        step(); set_m(0, 0, 32'd0, 32'd0, 0);
        step();

        // Repeated tie with master 0 granted last: master 1 goes first.
        step(); n = cyc_cnt;
        set_m(0, 1, 32'h1000_0010, 32'd0, 0);
        set_m(1, 1, 32'h2000_0010, 32'd0, 0);
        push(1, 32'h2000_0010, 0, n + 1);
        step();
        step(); set_m(1, 0, 32'd0, 32'd0, 0);
        push(0, 32'h1000_0010, 0, n + 3);
        step();
        step(); set_m(0, 0, 32'd0, 32'd0, 0);
        step();

        // Master 1 4-beat read burst; master 0 waits for the end of the burst.
        step(); n = cyc_cnt;
        set_m(1, 1, 32'h4000_0000, 32'd0, 0);
        push(1, 32'h4000_0000, 0, n + 1);
        step();
        set_m(0, 1, 32'h5000_0000, 32'd0, 0);
        for (int k = 1; k < 4; k++) begin
            step();
            adr1 = 32'h4000_0000 + 32'(4 * k);
            push(1, adr1, 0, n + 1 + k);
        end
        step(); set_m(1, 0, 32'd0, 32'd0, 0);
        push(0, 32'h5000_0000, 0, n + 6);
        @(negedge clk);
        chk("burst_ack0_waits", {63'd0, ack0}, 64'd0);
        step();
        step(); set_m(0, 0, 32'd0, 32'd0, 0);
        step();

        // Stalled peripheral: forced ack 8 cycles after stb, then again 9 cycles later.
        periph_en = 1'b0;
        step(); n = cyc_cnt;
        set_m(0, 1, 32'h6000_0000, 32'd0, 0);
        push(0, 32'h6000_0000, 1, n + 9);
        push(0, 32'h6000_0000, 1, n + 18);
        step();
        @(negedge clk);
        chk("to_stb_start", {63'd0, p_stb}, 64'd1);
        repeat (18) step();
        set_m(0, 0, 32'd0, 32'd0, 0);
        step();
        periph_en = 1'b1;

        // Timeout disabled: 1000 stalled cycles produce no ack, and the grant stays.
        step();
        z_cyc = 1'b1; z_stb = 1'b1;
        zc = 0;
        repeat (1000) begin
            step();
            @(negedge clk);
            if (z_ack0 || z_ack1) zc++;
        end
        chk("nto_no_ack", 64'(zc), 64'd0);
        chk("nto_grant_held", {62'd0, z_pcyc, z_pstb}, 64'd3);
        z_cyc = 1'b0; z_stb = 1'b0;
        step();

        // Asynchronous reset mid-transfer, then a tie goes to master 0.
        periph_en = 1'b0;
        step();
        set_m(0, 1, 32'h7000_0000, 32'h0BAD_F00D, 1);
        step();
        step();
        chk("pre_rst_cyc", {63'd0, p_cyc}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs", {23'd0, p_cyc, p_stb, p_we, ack0, ack1, p_sel, p_adr}, 64'd0);
        chk("async_rst_rdata", {dr0, dr1}, 64'd0);
        chk("async_rst_datwr", {32'd0, p_dw}, 64'd0);
        set_m(1, 1, 32'h8000_0000, 32'd0, 0);
        periph_en = 1'b1;
        step();
        rst = 1'b0; n = cyc_cnt;
        push(0, 32'h7000_0000, 0, n + 1);
        step();
        step(); set_m(0, 0, 32'd0, 32'd0, 0);
        push(1, 32'h8000_0000, 0, n + 3);
        step();
        step(); set_m(1, 0, 32'd0, 32'd0, 0);
        repeat (3) step();

        chk("sb_drain", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Two-master to one-peripheral Wishbone classic arbiter: it is the inbound counterpart of the address-decoding `wb_mux`. It lets the management SoC bus (master 0) and an on-chip sequencer (master 1) share one Wishbone peripheral tree. Arbitration is round-robin and the grant is held for the whole `cyc` burst. A per-transfer timeout terminates stalled accesses so that neither master can hang the bus.

## Interface
- `TIMEOUT_CYCLES`, default 256: stalled-strobe cycles before forced termination. 0 disables the timeout. Legal range is 0..65535.
- `TIMEOUT_DATA`, default 32'hDEAD_BEEF: read data returned on a forced termination.
- `io_wbs_clk`  input  1  single clock; all logic is on the rising edge.
- `io_wbs_rst`  input  1  asynchronous, active-high reset.
- `io_wbs_adr_0`, `io_wbs_adr_1`  input  32  master address.
- `io_wbs_datwr_0`, `io_wbs_datwr_1`  input  32  master write data.
- `io_wbs_datrd_0`, `io_wbs_datrd_1`  output  32  master read data.
- `io_wbs_we_0`, `io_wbs_we_1`  input  1  master write enable.
- `io_wbs_sel_0`, `io_wbs_sel_1`  input  4  master byte select.
- `io_wbs_stb_0`, `io_wbs_stb_1`  input  1  master strobe.
- `io_wbs_ack_0`, `io_wbs_ack_1`  output  1  master acknowledge.
- `io_wbs_cyc_0`, `io_wbs_cyc_1`  input  1  master cycle (bus request).
- `io_wbs_adr`, `io_wbs_datwr`  output  32  peripheral address and write data.
- `io_wbs_datrd`  input  32  peripheral read data.
- `io_wbs_we`, `io_wbs_stb`, `io_wbs_cyc`  output  1  peripheral controls.
- `io_wbs_sel`  output  4  peripheral byte select.
- `io_wbs_ack`  input  1  peripheral acknowledge.

## Operation
- The FSM has three states: IDLE, GNT0, GNT1. The state register and `last` (the last-granted master, 1 bit) are the only arbitration state.
- Reset values: state = IDLE, `last` = 1 (master 0 wins the first tie), timeout counter = 0.
- Every output is 0 in reset and in IDLE.
- IDLE transitions:
  - only `cyc_0` high → GNT0.
  - only `cyc_1` high → GNT1.
  - both high → grant the master ≠ `last`.
- Entering GNTn sets `last` = n.
- GNTn, `cyc_n` still high → stay. The grant is never pre-empted.
- GNTn, `cyc_n` low:
  - the other master's `cyc` is high → switch directly to the other grant.
  - otherwise → IDLE.
- While in GNTn, the peripheral outputs `adr`/`datwr`/`we`/`sel`/`stb`/`cyc` are combinationally driven from master n.
  - `datrd_n` = `io_wbs_datrd`; `ack_n` = `io_wbs_ack`.
  - The non-granted master sees `ack` = 0 and `datrd` = 0.
- Timeout counter (16 bit):
  - Increments each cycle the granted `stb` is high and `io_wbs_ack` is low.
  - Clears to 0 on `io_wbs_ack`, on granted `stb` low, or on a grant change.
- Forced termination: when the counter equals `TIMEOUT_CYCLES`−1 and `TIMEOUT_CYCLES` ≠ 0, the next cycle is a forced-ack cycle.
  - The granted master sees `ack` = 1 and `datrd` = `TIMEOUT_DATA`.
  - `io_wbs_stb` is forced to 0; `io_wbs_cyc` stays high.
  - The counter clears to 0.
- A peripheral `ack` arriving in the forced-ack cycle is ignored.

## Timing
- Grant latency: `cyc` rising in cycle t (bus IDLE) → peripheral `stb`/`cyc` valid in cycle t+1. Minimum single transfer is 2 cycles with a zero-wait peripheral.
- Hand-over: the current master drops `cyc` in cycle t while the other master's `cyc` is high → the other master is granted at t+1. There is no idle bubble.
- Once granted, the data and ack paths are purely combinational, with zero added latency per beat.
- Timeout: with `stb` held from cycle t and no ack, the forced ack appears in cycle t+`TIMEOUT_CYCLES`.
- Simultaneous `cyc_0` and `cyc_1` rising in the same cycle from IDLE → resolved by `last` as above.
- `io_wbs_rst` asserted mid-transfer → immediately (asynchronously) state = IDLE, all outputs 0, `last` = 1. Any in-flight peripheral ack after that is ignored.

## Test plan
- Reset, then only master 0 writes `adr` = 0x3000_0004, `datwr` = 0x1234_5678, `sel` = 0xF.
  - Peripheral sees identical signals one cycle after `cyc_0`.
  - Peripheral ack returns as `ack_0`; `ack_1` = 0.
- Both masters raise `cyc` in the same cycle after reset → master 0 granted first.
  - On its release, master 1 is granted the next cycle.
  - A repeated tie then grants master 1 first.
- Master 1 holds `cyc` for a 4-beat read burst while master 0 requests → master 0 waits all 4 acks, then is granted in the cycle after `cyc_1` falls.
- Peripheral never acks, `TIMEOUT_CYCLES` = 8 → granted master sees `ack` = 1 with `datrd` = 0xDEAD_BEEF exactly 8 cycles after `stb`, and `io_wbs_stb` = 0 in that cycle.
- `TIMEOUT_CYCLES` = 0 with no ack for 1000 cycles → no ack is generated and the grant is held.
- Assert `io_wbs_rst` mid-burst → all outputs 0 without waiting for a clock edge.
  - After reset release, both masters requesting → master 0 granted.
